// File: rtl/adder_seq_pkg.sv
// Shared types and default sizing for the adder_tree accumulation sequencer.
package adder_seq_pkg;

  localparam int unsigned BEATS_DEF    = 32;
  localparam int unsigned TREE_LAT_DEF = 3;
  localparam int unsigned ACC_W_DEF    = 32;
  localparam int unsigned ADDR_W       = 6;
  localparam int unsigned LANES        = 8;
  localparam int unsigned LANE_W       = 8;
  localparam int unsigned SUM_W        = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Address of the final beat of a job.
  function automatic logic [ADDR_W-1:0] last_beat(input int unsigned beats);
    return ADDR_W'(beats - 1);
  endfunction

endpackage

// File: rtl/adder_tree_sequencer_valid_delay_line.sv
// Fixed-depth 1-bit valid shift pipe with synchronous clear and an in-flight flag.
module valid_delay_line #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic any_valid_c
);

  logic [DEPTH-1:0] pipe;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst || clr) pipe <= '0;
        else            pipe <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst || clr) pipe <= '0;
        else            pipe <= {pipe[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout        = pipe[DEPTH-1];
  assign any_valid_c = |pipe;

endmodule

// File: rtl/adder_tree_sequencer.sv
// Runs one accumulation job: streams BEATS buffer reads into adder_tree and
// sums the per-beat results that come back TREE_LAT cycles later.
module adder_tree_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned BEATS    = BEATS_DEF,
  parameter int unsigned TREE_LAT = TREE_LAT_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tree_in_valid,
  input  logic [SUM_W-1:0]  sum_in,
  output logic [ACC_W-1:0]  result,
  output logic [7:0]        led
);

  localparam logic [ADDR_W-1:0] LAST_BEAT = last_beat(BEATS);

  seq_state_t        state, state_n;
  logic [ADDR_W-1:0] beat_cnt, beat_n;
  logic [ACC_W-1:0]  acc;
  logic              accept_c;
  logic              sum_valid;
  logic              pipe_busy_c;

  // Tags which sum_in cycles carry a real beat result.
  valid_delay_line #(
    .DEPTH (TREE_LAT)
  ) u_sum_tag (
    .clk         (clk),
    .rst         (rst),
    .clr         (accept_c),
    .din         (tree_in_valid),
    .dout        (sum_valid),
    .any_valid_c (pipe_busy_c)
  );

  always_comb begin
    state_n  = state;
    beat_n   = beat_cnt;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = ISSUE;
          beat_n   = '0;
          accept_c = 1'b1;
        end
      end
      ISSUE: begin
        if (beat_cnt == LAST_BEAT) state_n = DRAIN;
        else                       beat_n  = beat_cnt + ADDR_W'(1);
      end
      // Done only once the buffer-read stage and the tree pipe are both empty.
      DRAIN: begin
        if (!tree_in_valid && !pipe_busy_c) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      rd_en         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tree_in_valid <= 1'b0;
      acc           <= '0;
      result        <= '0;
    end else begin
      state         <= state_n;
      beat_cnt      <= beat_n;
      rd_en         <= (state_n == ISSUE);
      busy          <= (state_n == ISSUE) || (state_n == DRAIN);
      done          <= (state_n == DONE);
      tree_in_valid <= rd_en;
      if (accept_c)       acc <= '0;
      else if (sum_valid) acc <= acc + ACC_W'(sum_in);
      if (state_n == DONE) result <= acc;
    end
  end

  assign rd_addr = beat_cnt;
  assign led     = result[15:8];

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed bench with lane-buffer and adder_tree models and a done-driven scoreboard.
module tb_adder_tree_sequencer;
  import adder_seq_pkg::*;

  localparam int unsigned BEATS = 32;
  localparam int unsigned TL    = 3;
  localparam int unsigned ACC_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, rd_en, tree_in_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [SUM_W-1:0]  sum_in;
  logic [ACC_W-1:0]  result;
  logic [7:0]        led;

  adder_tree_sequencer #(.BEATS(BEATS), .TREE_LAT(TL), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .tree_in_valid (tree_in_valid),
    .sum_in        (sum_in),
    .result        (result),
    .led           (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at_cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int pat_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  // Lane buffers: 1-cycle registered read, all eight lanes share one pattern.
  function automatic logic [7:0] lane_val(input int mode, input logic [ADDR_W-1:0] addr);
    case (mode)
      0:       return 8'd1;
      1:       return 8'd255;
      default: return 8'(addr);
    endcase
  endfunction

  logic [7:0]  lane_q [8] = '{default: 8'd0};
  logic [31:0] lane_sum_c;
  logic [31:0] tstage [TL] = '{default: 32'd0};

  always @(posedge clk)
    if (rd_en) for (int l = 0; l < 8; l++) lane_q[l] <= lane_val(pat_mode, rd_addr);

  always_comb begin
    lane_sum_c = '0;
    for (int l = 0; l < 8; l++) lane_sum_c = lane_sum_c + 32'(lane_q[l]);
  end

  // Tree model: garbage on non-valid slots so untagged sums would corrupt the total.
  always @(posedge clk) begin
    tstage[0] <= tree_in_valid ? lane_sum_c : 32'hDEAD_BEEF;
    for (int i = 1; i < TL; i++) tstage[i] <= tstage[i-1];
  end
  assign sum_in = tstage[TL-1];

  int addr_exp = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rd_en) begin
      check("rd_addr", 32'(rd_addr), 32'(addr_exp));
      addr_exp = (addr_exp == BEATS - 1) ? 0 : addr_exp + 1;
    end
    if (rst) addr_exp = 0;
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("led", 32'(led), 32'(e.res[15:8]));
        check("done_cycle", 32'(cyc), 32'(e.at_cyc));
      end
    end
  end

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_tree_in_valid"}, 32'(tree_in_valid), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
  endtask

  task automatic run_job(input int mode, input logic [31:0] exp_res);
    int n0;
    pat_mode = mode;
    n0 = cyc;
    start = 1'b1;
    sb_q.push_back('{res: exp_res, at_cyc: n0 + 38});
    @(negedge clk);
    start = 1'b0;
    go_to(n0 + 42);
  endtask

  initial begin
    int n0, n1;
    go_to(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    go_to(5);

    // All lanes 1: timing of busy/done around the job.
    pat_mode = 0;
    n0 = cyc;
    start = 1'b1;
    sb_q.push_back('{res: 32'd256, at_cyc: n0 + 38});
    @(negedge clk);
    start = 1'b0;
    check("busy_edge0", 32'(busy), 32'd1);
    check("tiv_edge0", 32'(tree_in_valid), 32'd0);
    go_to(n0 + 2);
    check("tiv_edge1", 32'(tree_in_valid), 32'd1);
    go_to(n0 + 37);
    check("busy_edge36", 32'(busy), 32'd1);
    check("done_early", 32'(done), 32'd0);
    go_to(n0 + 38);
    check("busy_in_done", 32'(busy), 32'd0);
    go_to(n0 + 39);
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_held", result, 32'd256);
    go_to(n0 + 42);

    run_job(1, 32'd65280);
    run_job(2, 32'd3968);

    // Extra start pulses while busy are ignored.
    pat_mode = 0;
    n0 = cyc;
    start = 1'b1;
    sb_q.push_back('{res: 32'd256, at_cyc: n0 + 38});
    @(negedge clk);
    start = 1'b0;
    go_to(n0 + 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    go_to(n0 + 20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    go_to(n0 + 45);

    // Reset at edge 15 aborts; immediate restart must not see stale sums.
    pat_mode = 2;
    n0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    go_to(n0 + 15);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midjob_rst");
    rst = 1'b0;
    n1 = cyc;
    start = 1'b1;
    sb_q.push_back('{res: 32'd3968, at_cyc: n1 + 38});
    @(negedge clk);
    start = 1'b0;
    go_to(n1 + 42);

    // start held high: back-to-back jobs with acc cleared in between.
    pat_mode = 0;
    n0 = cyc;
    start = 1'b1;
    sb_q.push_back('{res: 32'd256, at_cyc: n0 + 38});
    sb_q.push_back('{res: 32'd256, at_cyc: n0 + 77});
    go_to(n0 + 39);
    check("b2b_idle_rd_en", 32'(rd_en), 32'd0);
    check("b2b_done_low", 32'(done), 32'd0);
    go_to(n0 + 40);
    check("b2b_rd_en_start", 32'(rd_en), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    go_to(n0 + 45);
    start = 1'b0;
    go_to(n0 + 82);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
